// File: rtl/vram_sched_pkg.sv
// ============================================================================
//  Module   : vram_sched_pkg
//  Brief    : Shared types and constants for the VRAM write scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vram_sched_pkg;

    // Scheduler states; explicit 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } sched_state_t;

    // VRAM window base in the CPU map; scheduler addresses are offsets from it.
    localparam logic [15:0] VRAM_BASE = 16'h3700;

    // Native offset width of the VRAM window.
    localparam int VRAM_ADDR_W = 12;

    // One queued CPU write.
    typedef struct packed {
        logic [VRAM_ADDR_W-1:0] addr;
        logic [7:0]             data;
    } vram_entry_t;

    // CPU-visible absolute address of a VRAM offset (for debug views).
    function automatic logic [15:0] vram_abs_addr(input logic [VRAM_ADDR_W-1:0] offset);
        return VRAM_BASE + 16'(offset);
    endfunction

endpackage

`default_nettype wire

// File: rtl/vram_write_scheduler_m_fifo.sv
// ============================================================================
//  Module   : sync_fifo_m
//  Brief    : Single-clock register-array FIFO with occupancy, full and empty.
//             DEPTH must be a power of two so the pointers wrap naturally.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_m #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int                 c_PTR_W      = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL_LEVEL = DEPTH[c_PTR_W:0];

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_level;
    logic               w_do_push;
    logic               w_do_pop;

    // A push into a full FIFO or a pop from an empty one is ignored here,
    // so callers cannot corrupt the pointers even if they misbehave.
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop  && !o_empty;

    assign o_full  = (r_level == c_FULL_LEVEL);
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_rdata = r_mem[r_rd_ptr];

    // Pointer and occupancy tracking; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

endmodule

`default_nettype wire

// File: rtl/vram_write_scheduler_m.sv
// ============================================================================
//  Module   : vram_write_scheduler_m
//  Brief    : Queues CPU writes to VRAM and issues them on the shared VRAM
//             write port in GPU-free slots or vblank; a starvation guard
//             stalls one GPU fetch to force a slot for a long-waiting head.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vram_write_scheduler_m
    import vram_sched_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int ADDR_W       = VRAM_ADDR_W,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                       clk_12_5875,
    input  logic                       rst,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [ADDR_W-1:0]          wr_address,
    input  logic [7:0]                 wr_data,
    input  logic                       gpu_fetch_busy,
    input  logic                       in_vblank,
    output logic                       gpu_stall,
    output logic                       vram_we,
    output logic [ADDR_W-1:0]          vram_address,
    output logic [7:0]                 vram_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    input  logic                       clr_overflow
);

    localparam int                  c_LVL_W       = $clog2(DEPTH) + 1;
    localparam int                  c_FIFO_W      = ADDR_W + 8;
    localparam logic [c_LVL_W-1:0]  c_LVL_ONE     = {{(c_LVL_W-1){1'b0}}, 1'b1};
    localparam logic [7:0]          c_STARVE_LAST = 8'(STARVE_LIMIT - 1);

    sched_state_t          r_state;
    sched_state_t          w_state_next;
    logic [7:0]            r_starve_cnt;
    logic [7:0]            w_starve_next;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_free;
    logic                  w_full;
    logic                  w_empty;
    logic [c_LVL_W-1:0]    w_level;
    logic [c_FIFO_W-1:0]   w_fifo_wdata;
    logic [c_FIFO_W-1:0]   w_fifo_rdata;
    vram_entry_t           w_head;
    logic                  r_vram_we;
    logic [ADDR_W-1:0]     r_vram_address;
    logic [7:0]            r_vram_data;
    logic                  r_overflow;

    // Acceptance looks only at registered full, so a push that coincides
    // with a pop at full is still refused (and counted as a drop).
    assign w_push       = wr_valid && !w_full;
    assign w_drop       = wr_valid &&  w_full;
    assign w_free       = in_vblank || !gpu_fetch_busy;
    assign w_fifo_wdata = {wr_address, wr_data};

    // Head entry viewed through the shared entry type.
    assign w_head.addr = VRAM_ADDR_W'(w_fifo_rdata[c_FIFO_W-1:8]);
    assign w_head.data = w_fifo_rdata[7:0];

    sync_fifo_m #(
        .DEPTH (DEPTH),
        .WIDTH (c_FIFO_W)
    ) u_fifo (
        .clk     (clk_12_5875),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_fifo_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // State and starvation counter registers.
    always_ff @(posedge clk_12_5875 or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_next;
            r_starve_cnt <= w_starve_next;
        end
    end

    // Next-state, pop decision and starvation counting. The forced pop is
    // taken on the edge into FORCE so the registered write is on the port
    // during the very cycle the GPU fetch is stalled.
    always_comb begin
        w_state_next  = r_state;
        w_starve_next = r_starve_cnt;
        w_pop         = 1'b0;
        case (r_state)
            IDLE: begin
                w_starve_next = '0;
                if (w_push) begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                if (w_free) begin
                    w_pop         = 1'b1;
                    w_starve_next = '0;
                    if ((w_level == c_LVL_ONE) && !w_push) begin
                        w_state_next = IDLE;
                    end
                end else if (r_starve_cnt == c_STARVE_LAST) begin
                    w_pop         = 1'b1;
                    w_starve_next = '0;
                    w_state_next  = FORCE;
                end else begin
                    w_starve_next = r_starve_cnt + 8'd1;
                end
            end
            FORCE: begin
                w_starve_next = '0;
                w_state_next  = (!w_empty || w_push) ? WAIT : IDLE;
            end
            default: begin
                w_starve_next = '0;
                w_state_next  = IDLE;
            end
        endcase
    end

    // Registered VRAM write port; one strobe per popped entry.
    always_ff @(posedge clk_12_5875 or posedge rst) begin
        if (rst) begin
            r_vram_we      <= 1'b0;
            r_vram_address <= '0;
            r_vram_data    <= '0;
        end else begin
            r_vram_we <= w_pop;
            if (w_pop) begin
                r_vram_address <= ADDR_W'(w_head.addr);
                r_vram_data    <= w_head.data;
            end
        end
    end

    // Sticky drop flag; a new drop outranks a simultaneous clear.
    always_ff @(posedge clk_12_5875 or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    assign wr_ready     = !w_full;
    assign gpu_stall    = (r_state == FORCE);
    assign vram_we      = r_vram_we;
    assign vram_address = r_vram_address;
    assign vram_data    = r_vram_data;
    assign level        = w_level;
    assign overflow     = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_vram_write_scheduler_m.sv
// ============================================================================
//  Module   : tb_vram_write_scheduler_m
//  Brief    : Directed self-checking bench for vram_write_scheduler_m.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_vram_write_scheduler_m;

    localparam int DEPTH        = 8;
    localparam int ADDR_W       = 12;
    localparam int STARVE_LIMIT = 15;

    logic                    clk_12_5875 = 1'b0;
    logic                    rst;
    logic                    wr_valid;
    logic                    wr_ready;
    logic [ADDR_W-1:0]       wr_address;
    logic [7:0]              wr_data;
    logic                    gpu_fetch_busy;
    logic                    in_vblank;
    logic                    gpu_stall;
    logic                    vram_we;
    logic [ADDR_W-1:0]       vram_address;
    logic [7:0]              vram_data;
    logic [$clog2(DEPTH):0]  level;
    logic                    overflow;
    logic                    clr_overflow;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_12_5875 = ~clk_12_5875;

    vram_write_scheduler_m #(
        .DEPTH        (DEPTH),
        .ADDR_W       (ADDR_W),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk_12_5875    (clk_12_5875),
        .rst            (rst),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_address     (wr_address),
        .wr_data        (wr_data),
        .gpu_fetch_busy (gpu_fetch_busy),
        .in_vblank      (in_vblank),
        .gpu_stall      (gpu_stall),
        .vram_we        (vram_we),
        .vram_address   (vram_address),
        .vram_data      (vram_data),
        .level          (level),
        .overflow       (overflow),
        .clr_overflow   (clr_overflow)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk_12_5875);
        #1;
    endtask

    task automatic push_one(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        wr_valid   = 1'b1;
        wr_address = a;
        wr_data    = d;
        tick();
        wr_valid   = 1'b0;
    endtask

    initial begin
        int seen;
        int pulses;
        logic done;

        rst            = 1'b1;
        wr_valid       = 1'b0;
        wr_address     = '0;
        wr_data        = '0;
        gpu_fetch_busy = 1'b0;
        in_vblank      = 1'b0;
        clr_overflow   = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check_eq("rst_level",    32'(level),        0);
        check_eq("rst_wr_ready", 32'(wr_ready),     1);
        check_eq("rst_vram_we",  32'(vram_we),      0);
        check_eq("rst_address",  32'(vram_address), 0);
        check_eq("rst_data",     32'(vram_data),    0);
        check_eq("rst_stall",    32'(gpu_stall),    0);
        check_eq("rst_overflow", 32'(overflow),     0);

        // 1. single write with the port free
        push_one(12'h010, 8'hAA);
        check_eq("t1_level_after_push", 32'(level),   1);
        check_eq("t1_we_not_yet",       32'(vram_we), 0);
        tick();
        check_eq("t1_we",      32'(vram_we),      1);
        check_eq("t1_address", 32'(vram_address), 32'h010);
        check_eq("t1_data",    32'(vram_data),    32'hAA);
        check_eq("t1_level",   32'(level),        0);
        tick();
        check_eq("t1_we_single_pulse", 32'(vram_we), 0);

        // 2. fill while GPU is busy, then overflow and clear
        gpu_fetch_busy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push_one(12'h100 + 12'(i), 8'h10 + 8'(i));
        end
        check_eq("t2_level_full", 32'(level),    8);
        check_eq("t2_not_ready",  32'(wr_ready), 0);
        check_eq("t2_no_we",      32'(vram_we),  0);
        push_one(12'h1FF, 8'hFF);
        check_eq("t2_overflow_set", 32'(overflow), 1);
        check_eq("t2_level_kept",   32'(level),    8);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check_eq("t2_overflow_clr", 32'(overflow), 0);

        // 4. vblank drains the full queue back-to-back in push order
        in_vblank = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("t4_we_%0d", i),   32'(vram_we),      1);
            check_eq($sformatf("t4_addr_%0d", i), 32'(vram_address), 32'h100 + i);
            check_eq($sformatf("t4_data_%0d", i), 32'(vram_data),    32'h10 + i);
            tick();
        end
        check_eq("t4_we_end",    32'(vram_we), 0);
        check_eq("t4_level_end", 32'(level),   0);
        in_vblank = 1'b0;

        // 5. push at full coincident with a pop is refused
        for (int i = 0; i < 8; i++) begin
            push_one(12'h200 + 12'(i), 8'h20 + 8'(i));
        end
        check_eq("t5_level_full", 32'(level), 8);
        gpu_fetch_busy = 1'b0;
        wr_valid       = 1'b1;
        wr_address     = 12'h2FF;
        wr_data        = 8'hEE;
        tick();
        wr_valid = 1'b0;
        check_eq("t5_level_7",   32'(level),        7);
        check_eq("t5_we",        32'(vram_we),      1);
        check_eq("t5_addr_head", 32'(vram_address), 32'h200);
        check_eq("t5_drop_flag", 32'(overflow),     1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check_eq("t5_addr_next", 32'(vram_address), 32'h201);
        pulses = 0;
        done   = 1'b0;
        for (int k = 0; k < 12 && !done; k++) begin
            tick();
            if (vram_we) begin
                pulses++;
            end
            if (level == 0 && !vram_we) begin
                done = 1'b1;
            end
        end
        check_eq("t5_drain_in_time", 32'(done),     1);
        check_eq("t5_pulses_rest",   32'(pulses),   6);
        check_eq("t5_last_addr",     32'(vram_address), 32'h207);
        check_eq("t5_overflow_clr",  32'(overflow), 0);

        // 3. starvation guard: one entry, GPU permanently busy
        gpu_fetch_busy = 1'b1;
        push_one(12'h321, 8'h5C);
        seen = 0;
        for (int k = 0; k < STARVE_LIMIT - 1; k++) begin
            if (gpu_stall || vram_we) begin
                seen++;
            end
            tick();
        end
        if (gpu_stall || vram_we) begin
            seen++;
        end
        check_eq("t3_quiet_while_waiting", 32'(seen), 0);
        tick();
        check_eq("t3_stall",   32'(gpu_stall),    1);
        check_eq("t3_we",      32'(vram_we),      1);
        check_eq("t3_address", 32'(vram_address), 32'h321);
        check_eq("t3_data",    32'(vram_data),    32'h5C);
        check_eq("t3_level",   32'(level),        0);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (gpu_stall || vram_we) begin
                seen++;
            end
        end
        check_eq("t3_no_second_stall", 32'(seen), 0);

        // 6. reset with queued writes discards them
        for (int i = 0; i < 5; i++) begin
            push_one(12'h400 + 12'(i), 8'h40 + 8'(i));
        end
        check_eq("t6_level_before", 32'(level), 5);
        rst = 1'b1;
        #2;
        check_eq("t6_level_async", 32'(level), 0);
        tick();
        tick();
        rst            = 1'b0;
        gpu_fetch_busy = 1'b0;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (vram_we) begin
                seen++;
            end
        end
        check_eq("t6_no_we",     32'(seen),     0);
        check_eq("t6_level",     32'(level),    0);
        check_eq("t6_overflow",  32'(overflow), 0);
        check_eq("t6_wr_ready",  32'(wr_ready), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
